// File: rtl/btn_debounce_pkg.sv
// Shared board constants and types for the push-button debouncer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package btn_debounce_pkg;

  // 10 ms at 50 MHz; counter must satisfy 2**CNT_W > DEBOUNCE_CYCLES.
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int CNT_W_DEF           = 20;
  localparam int PCNT_W              = 8;

  typedef logic [PCNT_W-1:0] pcnt_t;

  // Everything one debounced channel reports to the outside world.
  typedef struct packed {
    logic  level;
    logic  press;
    logic  rel;
    logic  toggle;
    pcnt_t press_cnt;
  } ch_out_t;

endpackage

// File: rtl/btn_debounce_if.sv
// Button pins in, debounced levels/pulses/toggles/counters out.
// Latency: n/a (wiring only).
// Backpressure: none; pins and outputs are free-running levels and pulses.
interface btn_debounce_if;
  import btn_debounce_pkg::*;

  logic  btn1;
  logic  btn2;
  logic  level1;
  logic  level2;
  logic  press1;
  logic  press2;
  logic  release1;
  logic  release2;
  logic  toggle1;
  logic  toggle2;
  pcnt_t press_cnt1;
  pcnt_t press_cnt2;

  // Board / testbench side: drives the pins, observes the results.
  modport master (
    output btn1, btn2,
    input  level1, level2, press1, press2, release1, release2,
    input  toggle1, toggle2, press_cnt1, press_cnt2
  );

  // Debouncer side.
  modport slave (
    input  btn1, btn2,
    output level1, level2, press1, press2, release1, release2,
    output toggle1, toggle2, press_cnt1, press_cnt2
  );

endinterface

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop sync, stable level, run counter, pulses, toggle, press count.
// Latency: level change visible DEBOUNCE_CYCLES+2 edges after the pin settles.
// Backpressure: none; pulses are single-cycle and cannot be stalled.
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    btn,
  output ch_out_t out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             press;
  logic             rel;
  logic             toggle;
  pcnt_t            press_cnt;

  // Bring the asynchronous pin into the clock domain before anything looks at it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive mismatching samples;
  // the acceptance cycle also fires the edge pulse and updates toggle/count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable    <= 1'b0;
      cnt       <= '0;
      press     <= 1'b0;
      rel       <= 1'b0;
      toggle    <= 1'b0;
      press_cnt <= '0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
        press  <= sync2;
        rel    <= ~sync2;
        if (sync2) begin
          toggle    <= ~toggle;
          press_cnt <= press_cnt + PCNT_W'(1);
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign out.level     = stable;
  assign out.press     = press;
  assign out.rel       = rel;
  assign out.toggle    = toggle;
  assign out.press_cnt = press_cnt;

endmodule

// File: rtl/btn_debounce.sv
// Two independent push-button debounce channels behind one interface.
// Latency: DEBOUNCE_CYCLES+2 edges from a settled pin to level/pulse outputs.
// Backpressure: none; both channels run every cycle with no priority.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  btn_debounce_if.slave bus
);

  ch_out_t ch1_out;
  ch_out_t ch2_out;

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_ch1 (
    .clk (clk),
    .rst (rst),
    .btn (bus.btn1),
    .out (ch1_out)
  );

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_ch2 (
    .clk (clk),
    .rst (rst),
    .btn (bus.btn2),
    .out (ch2_out)
  );

  assign bus.level1     = ch1_out.level;
  assign bus.press1     = ch1_out.press;
  assign bus.release1   = ch1_out.rel;
  assign bus.toggle1    = ch1_out.toggle;
  assign bus.press_cnt1 = ch1_out.press_cnt;

  assign bus.level2     = ch2_out.level;
  assign bus.press2     = ch2_out.press;
  assign bus.release2   = ch2_out.rel;
  assign bus.toggle2    = ch2_out.toggle;
  assign bus.press_cnt2 = ch2_out.press_cnt;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with DEBOUNCE_CYCLES=4, CNT_W=3.
// Expected press/release events are queued when pins are driven and popped when pulses appear.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
module tb_btn_debounce;

  localparam int DEB = 4;
  localparam int LAT = DEB + 2;

  typedef struct {
    int         cyc;
    bit         kind;   // 1 = press, 0 = release
    bit         tog;
    logic [7:0] cnt;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  ev_t        q1[$];
  ev_t        q2[$];
  bit         exp_tog[2];
  logic [7:0] exp_cnt[2];

  btn_debounce_if bus ();

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({bus.level1, bus.level2, bus.press1, bus.press2, bus.release1,
                 bus.release2, bus.toggle1, bus.toggle2, bus.press_cnt1, bus.press_cnt2});
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Queue an accepted event for channel ch, LAT edges after the current point.
  task automatic push_exp(input int ch, input bit kind);
    ev_t e;
    if (kind) begin
      exp_tog[ch-1] = ~exp_tog[ch-1];
      exp_cnt[ch-1] = exp_cnt[ch-1] + 8'd1;
    end
    e.cyc  = cyc + LAT;
    e.kind = kind;
    e.tog  = exp_tog[ch-1];
    e.cnt  = exp_cnt[ch-1];
    if (ch == 1) q1.push_back(e);
    else         q2.push_back(e);
  endtask

  task automatic set_btn(input int ch, input bit v, input bit accept);
    if (ch == 1) bus.btn1 = v;
    else         bus.btn2 = v;
    if (accept) push_exp(ch, v);
  endtask

  task automatic mon(input int ch, input logic p, input logic r, input logic lv,
                     input logic tg, input logic [7:0] cnt);
    ev_t e;
    int  sz;
    if (p && r) chk($sformatf("ch%0d_press_and_release", ch), int'(p && r), 0);
    if (p || r) begin
      sz = (ch == 1) ? q1.size() : q2.size();
      chk($sformatf("ch%0d_event_expected", ch), int'(sz > 0), 1);
      if (sz > 0) begin
        e = (ch == 1) ? q1.pop_front() : q2.pop_front();
        chk($sformatf("ch%0d_kind", ch), int'(p), int'(e.kind));
        chk($sformatf("ch%0d_cycle", ch), cyc, e.cyc);
        chk($sformatf("ch%0d_level", ch), int'(lv), int'(e.kind));
        chk($sformatf("ch%0d_toggle", ch), int'(tg), int'(e.tog));
        chk($sformatf("ch%0d_cnt", ch), int'(cnt), int'(e.cnt));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(1, bus.press1, bus.release1, bus.level1, bus.toggle1, bus.press_cnt1);
      mon(2, bus.press2, bus.release2, bus.level2, bus.toggle2, bus.press_cnt2);
    end
  end

  // Hold reset for n cycles, checking every output reads zero meanwhile.
  task automatic do_reset(input int n);
    rst = 1'b1;
    exp_tog[0] = 1'b0; exp_tog[1] = 1'b0;
    exp_cnt[0] = 8'd0; exp_cnt[1] = 8'd0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      chk("reset_outs", all_outs(), 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.btn1 = 1'b0;
    bus.btn2 = 1'b0;
    exp_tog[0] = 1'b0; exp_tog[1] = 1'b0;
    exp_cnt[0] = 8'd0; exp_cnt[1] = 8'd0;
    tick(1);

    // Reset with buttons idle; outputs stay quiet afterwards.
    do_reset(3);
    tick(10);
    chk("idle_after_reset", all_outs(), 0);

    // Clean press on channel 1.
    set_btn(1, 1'b1, 1'b1);
    tick(8);
    chk("p1_level", int'(bus.level1), 1);
    chk("p1_toggle", int'(bus.toggle1), 1);
    chk("p1_cnt", int'(bus.press_cnt1), 1);
    chk("ch2_untouched", int'({bus.level2, bus.toggle2, bus.press_cnt2}), 0);
    set_btn(1, 1'b0, 1'b1);
    tick(8);
    chk("r1_level", int'(bus.level1), 0);

    // 3-cycle glitch is rejected, 4-cycle glitch is accepted.
    set_btn(1, 1'b1, 1'b0);
    tick(3);
    set_btn(1, 1'b0, 1'b0);
    tick(10);
    chk("glitch3_level", int'(bus.level1), 0);
    chk("glitch3_cnt", int'(bus.press_cnt1), 1);
    set_btn(1, 1'b1, 1'b1);
    tick(4);
    set_btn(1, 1'b0, 1'b1);
    tick(12);
    chk("glitch4_cnt", int'(bus.press_cnt1), 2);

    // Bouncing press then release on channel 2.
    set_btn(2, 1'b1, 1'b0); tick(1);
    set_btn(2, 1'b0, 1'b0); tick(1);
    set_btn(2, 1'b1, 1'b0); tick(1);
    set_btn(2, 1'b0, 1'b0); tick(1);
    set_btn(2, 1'b1, 1'b1);
    tick(10);
    chk("bounce_level2", int'(bus.level2), 1);
    chk("bounce_cnt2", int'(bus.press_cnt2), 1);
    set_btn(2, 1'b0, 1'b1);
    tick(10);
    chk("bounce_toggle2", int'(bus.toggle2), 1);
    chk("bounce_rel_level2", int'(bus.level2), 0);

    // Simultaneous press and release on both channels.
    set_btn(1, 1'b1, 1'b1);
    set_btn(2, 1'b1, 1'b1);
    tick(LAT);
    chk("simul_press", int'({bus.press1, bus.press2}), 3);
    tick(4);
    set_btn(1, 1'b0, 1'b1);
    set_btn(2, 1'b0, 1'b1);
    tick(LAT);
    chk("simul_release", int'({bus.release1, bus.release2}), 3);
    tick(4);

    // Counter wrap: 256 presses from a fresh reset.
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    do_reset(2);
    chk("reset_clear", all_outs(), 0);
    for (int i = 0; i < 256; i++) begin
      set_btn(1, 1'b1, 1'b1);
      tick(8);
      set_btn(1, 1'b0, 1'b1);
      tick(8);
    end
    chk("wrap_cnt", int'(bus.press_cnt1), 0);
    chk("wrap_toggle", int'(bus.toggle1), 0);

    // Reset in the middle of a debounce run (counter at 2), button held through it.
    set_btn(1, 1'b1, 1'b0);
    tick(4);
    do_reset(2);
    push_exp(1, 1'b1);
    tick(LAT);
    chk("post_reset_press", int'(bus.press1), 1);
    tick(4);
    chk("post_reset_cnt", int'(bus.press_cnt1), 1);

    tick(10);
    chk("q1_empty", q1.size(), 0);
    chk("q2_empty", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
